// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the instruction-fetch port
// and the data port. Only one transaction is outstanding at a time, and conflicts are
// resolved round-robin.
module mem_arbiter #(
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [31:0]  if_rdata,
  output logic         if_valid,
  input  logic         dm_readEnable,
  input  logic         dm_writeEnable,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  output logic [N-1:0] dm_rdata,
  output logic         dm_valid,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         mem_err,
  output logic         stall_if,
  output logic         stall_mem,
  output logic [1:0]   dbg_state_o
);
  // Handshake: a requester holds its request until its valid pulses for one cycle.
  // mem_req stays high with stable address and data until mem_ready is seen for one cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t         state_q, state_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [N-1:0]   mem_addr_q, mem_addr_d;
  logic [N-1:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]    if_rdata_q, if_rdata_d;
  logic [N-1:0]   dm_rdata_q, dm_rdata_d;
  logic           if_valid_q, if_valid_d;
  logic           dm_valid_q, dm_valid_d;
  logic           mem_err_q, mem_err_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           last_data_q, last_data_d;

  logic dm_req, if_req_m, dm_req_m;
  logic grant_if, grant_dm;

  assign dm_req   = dm_readEnable | dm_writeEnable;
  // A request is masked while its valid pulses, because the requester has not yet
  // seen completion and still holds the request.
  assign if_req_m = if_req & ~if_valid_q;
  assign dm_req_m = dm_req & ~dm_valid_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    mem_err_d   = 1'b0;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_m && dm_req_m) begin
          grant_if = last_data_q;
          grant_dm = ~last_data_q;
        end else begin
          grant_if = if_req_m;
          grant_dm = dm_req_m;
        end
        if (grant_if) begin
          state_d     = FETCH;
          mem_req_d   = 1'b1;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          last_data_d = 1'b0;
          cnt_d       = '0;
        end else if (grant_dm) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_addr_d  = dm_addr;
          mem_we_d    = dm_writeEnable;
          mem_wdata_d = dm_wdata;
          last_data_d = 1'b1;
          cnt_d       = '0;
        end
      end
      FETCH, DATA: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == FETCH) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata[31:0];
          end else begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = (cnt_q < TO) ? cnt_q + 16'd1 : cnt_q;
          // This wait cycle brings the counter to TIMEOUT, so the access is aborted.
          if (cnt_q >= TO - 16'd1) begin
            state_d    = IDLE;
            mem_req_d  = 1'b0;
            mem_err_d  = 1'b1;
            if_valid_d = (state_q == FETCH);
            dm_valid_d = (state_q == DATA);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      mem_err_q   <= 1'b0;
      cnt_q       <= '0;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      mem_err_q   <= mem_err_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_valid    = if_valid_q;
  assign dm_rdata    = dm_rdata_q;
  assign dm_valid    = dm_valid_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_err     = mem_err_q;
  assign stall_if    = if_req & ~if_valid_q;
  assign stall_mem   = dm_req & ~dm_valid_q;
  assign dbg_state_o = state_q;

endmodule
